// File: rtl/cache_data_banks.sv
// Banked data store for one L1 cache way: CPU word access, critical-word-first
// refill absorption and whole-line eviction reads over WORDS parallel banks.
module cache_data_banks #(
  parameter int WORD_W  = 32,
  parameter int WORDS   = 8,
  parameter int INDEX_W = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cpu_en,
  input  logic [WORD_W/8-1:0]               cpu_wen,
  input  logic [31:0]                       cpu_addr,
  input  logic [WORD_W-1:0]                 cpu_din,
  output logic                              cpu_ready,
  output logic [WORD_W-1:0]                 cpu_dout,
  output logic                              cpu_dout_valid,
  input  logic                              refill_start,
  input  logic [INDEX_W-1:0]                refill_index,
  input  logic [$clog2(WORDS)-1:0]          refill_offset,
  input  logic                              refill_valid,
  input  logic [WORD_W-1:0]                 refill_data,
  output logic                              refill_done,
  input  logic                              evict_req,
  input  logic [INDEX_W-1:0]                evict_index,
  output logic [WORDS*WORD_W-1:0]           evict_line,
  output logic                              evict_valid
);

  localparam int OFFSET_W = $clog2(WORDS);
  localparam int BYTES    = WORD_W / 8;
  localparam int SETS     = 1 << INDEX_W;
  localparam int CNT_W    = OFFSET_W + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, REFILL = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [INDEX_W-1:0]       idx_q, idx_d;
  logic [OFFSET_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     refill_done_q, refill_done_d;
  logic [WORD_W-1:0]        cpu_dout_q, cpu_dout_d;
  logic                     cpu_dout_valid_q, cpu_dout_valid_d;
  logic [WORDS*WORD_W-1:0]  evict_line_q, evict_line_d;
  logic                     evict_valid_q, evict_valid_d;

  logic [WORD_W-1:0]        mem [WORDS][SETS];

  logic [OFFSET_W-1:0]      cpu_off_s;
  logic [INDEX_W-1:0]       cpu_idx_s;
  logic                     idle_s, cpu_go_s, cpu_wr_s, cpu_rd_s, beat_s;
  logic [WORD_W-1:0]        cpu_merged_s;
  logic                     unused_addr_s;

  assign cpu_off_s     = cpu_addr[OFFSET_W+1:2];
  assign cpu_idx_s     = cpu_addr[INDEX_W+OFFSET_W+1:OFFSET_W+2];
  assign unused_addr_s = ^{cpu_addr[31:INDEX_W+OFFSET_W+2], cpu_addr[1:0]};

  assign idle_s    = (state_q == IDLE);
  assign cpu_ready = idle_s && !evict_req;
  assign cpu_go_s  = cpu_ready && !refill_start && cpu_en;
  assign cpu_wr_s  = cpu_go_s && (cpu_wen != {BYTES{1'b0}});
  assign cpu_rd_s  = cpu_go_s && (cpu_wen == {BYTES{1'b0}});
  assign beat_s    = !idle_s && refill_valid;

  // Byte-merge of the CPU write into the currently stored word.
  always_comb begin
    cpu_merged_s = mem[cpu_off_s][cpu_idx_s];
    for (int b = 0; b < BYTES; b++) begin
      if (cpu_wen[b]) begin
        cpu_merged_s[b*8 +: 8] = cpu_din[b*8 +: 8];
      end else begin
        cpu_merged_s[b*8 +: 8] = mem[cpu_off_s][cpu_idx_s][b*8 +: 8];
      end
    end
  end

  // Next-state logic; refill_start outranks evict_req which outranks the CPU.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    ptr_d            = ptr_q;
    cnt_d            = cnt_q;
    refill_done_d    = 1'b0;
    cpu_dout_d       = cpu_dout_q;
    cpu_dout_valid_d = 1'b0;
    evict_line_d     = evict_line_q;
    evict_valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (refill_start) begin
          state_d = REFILL;
          idx_d   = refill_index;
          ptr_d   = refill_offset;
          cnt_d   = {CNT_W{1'b0}};
        end else if (evict_req) begin
          for (int k = 0; k < WORDS; k++) begin
            evict_line_d[k*WORD_W +: WORD_W] = mem[k][evict_index];
          end
          evict_valid_d = 1'b1;
        end else if (cpu_rd_s) begin
          cpu_dout_d       = mem[cpu_off_s][cpu_idx_s];
          cpu_dout_valid_d = 1'b1;
        end else begin
          cpu_dout_valid_d = 1'b0;
        end
      end
      REFILL: begin
        if (refill_valid) begin
          ptr_d = ptr_q + OFFSET_W'(1);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WORDS - 1)) begin
            state_d       = IDLE;
            refill_done_d = 1'b1;
          end else begin
            state_d = REFILL;
          end
        end else begin
          state_d = REFILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      idx_q            <= {INDEX_W{1'b0}};
      ptr_q            <= {OFFSET_W{1'b0}};
      cnt_q            <= {CNT_W{1'b0}};
      refill_done_q    <= 1'b0;
      cpu_dout_q       <= {WORD_W{1'b0}};
      cpu_dout_valid_q <= 1'b0;
      evict_line_q     <= {(WORDS*WORD_W){1'b0}};
      evict_valid_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      ptr_q            <= ptr_d;
      cnt_q            <= cnt_d;
      refill_done_q    <= refill_done_d;
      cpu_dout_q       <= cpu_dout_d;
      cpu_dout_valid_q <= cpu_dout_valid_d;
      evict_line_q     <= evict_line_d;
      evict_valid_q    <= evict_valid_d;
    end
  end

  // RAM write port; contents survive reset since tag valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!rst && beat_s) begin
      mem[ptr_q][idx_q] <= refill_data;
    end else if (!rst && cpu_wr_s) begin
      mem[cpu_off_s][cpu_idx_s] <= cpu_merged_s;
    end
  end

  assign refill_done    = refill_done_q;
  assign cpu_dout       = cpu_dout_q;
  assign cpu_dout_valid = cpu_dout_valid_q;
  assign evict_line     = evict_line_q;
  assign evict_valid    = evict_valid_q;

endmodule

// File: tb/tb_cache_data_banks.sv
// Directed plus randomized bench for cache_data_banks against an array-of-words
// reference model of the cache way.
module tb_cache_data_banks;

  localparam int WORD_W  = 32;
  localparam int WORDS   = 8;
  localparam int INDEX_W = 7;
  localparam int SETS    = 1 << INDEX_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_en;
  logic [3:0]   cpu_wen;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_din;
  logic         cpu_ready;
  logic [31:0]  cpu_dout;
  logic         cpu_dout_valid;
  logic         refill_start;
  logic [6:0]   refill_index;
  logic [2:0]   refill_offset;
  logic         refill_valid;
  logic [31:0]  refill_data;
  logic         refill_done;
  logic         evict_req;
  logic [6:0]   evict_index;
  logic [255:0] evict_line;
  logic         evict_valid;

  logic [31:0]  ref_mem [WORDS][SETS];
  logic [31:0]  beats [WORDS];
  int           checks = 0;
  int           failures = 0;

  cache_data_banks #(.WORD_W(WORD_W), .WORDS(WORDS), .INDEX_W(INDEX_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ready(cpu_ready), .cpu_dout(cpu_dout), .cpu_dout_valid(cpu_dout_valid),
    .refill_start(refill_start), .refill_index(refill_index), .refill_offset(refill_offset),
    .refill_valid(refill_valid), .refill_data(refill_data), .refill_done(refill_done),
    .evict_req(evict_req), .evict_index(evict_index),
    .evict_line(evict_line), .evict_valid(evict_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_addr(input int idx, input int off);
    logic [31:0] a;
    a       = $urandom;
    a[11:5] = 7'(idx);
    a[4:2]  = 3'(off);
    return a;
  endfunction

  function automatic logic [255:0] exp_line(input int idx);
    logic [255:0] l;
    for (int k = 0; k < WORDS; k++) l[k*32 +: 32] = ref_mem[k][idx];
    return l;
  endfunction

  task automatic idle_inputs;
    cpu_en = 1'b0; cpu_wen = 4'h0; cpu_addr = 32'h0; cpu_din = 32'h0;
    refill_start = 1'b0; refill_index = 7'h0; refill_offset = 3'h0;
    refill_valid = 1'b0; refill_data = 32'h0;
    evict_req = 1'b0; evict_index = 7'h0;
  endtask

  task automatic do_refill(input int idx, input int off, input int gap, input bit rand_gap,
                           input bit conflict, input int nbeats, input int cidx, input int coff);
    int g;
    refill_start = 1'b1; refill_index = 7'(idx); refill_offset = 3'(off);
    if (conflict) begin
      evict_req = 1'b1; evict_index = 7'(cidx);
      cpu_en = 1'b1; cpu_wen = 4'hF; cpu_addr = mk_addr(cidx, coff); cpu_din = $urandom;
    end
    tick;
    if (conflict) begin
      check("conflict_evict_valid", evict_valid, 1'b0);
      check("conflict_dout_valid", cpu_dout_valid, 1'b0);
    end
    refill_start = 1'b0; evict_req = 1'b0; cpu_en = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      g = rand_gap ? int'($urandom_range(0, gap)) : gap;
      repeat (g) begin
        refill_valid = 1'b0;
        cpu_en = 1'b1; cpu_wen = 4'hF; cpu_din = $urandom;
        cpu_addr = mk_addr(int'($urandom_range(0, SETS - 1)), int'($urandom_range(0, WORDS - 1)));
        #1;
        check("gap_cpu_ready", cpu_ready, 1'b0);
        tick;
        check("gap_refill_done", refill_done, 1'b0);
      end
      cpu_en = 1'b0;
      refill_valid = 1'b1; refill_data = beats[i];
      #1;
      check("beat_cpu_ready", cpu_ready, 1'b0);
      tick;
      ref_mem[(off + i) % WORDS][idx] = beats[i];
      check("refill_done", refill_done, (i == WORDS - 1));
    end
    refill_valid = 1'b0;
  endtask

  task automatic cpu_write(input int idx, input int off, input logic [3:0] wen, input logic [31:0] din);
    cpu_en = 1'b1; cpu_wen = wen; cpu_din = din; cpu_addr = mk_addr(idx, off);
    #1;
    check("wr_cpu_ready", cpu_ready, 1'b1);
    tick;
    check("wr_dout_valid", cpu_dout_valid, 1'b0);
    check("wr_refill_done", refill_done, 1'b0);
    for (int b = 0; b < 4; b++)
      if (wen[b]) ref_mem[off][idx][b*8 +: 8] = din[b*8 +: 8];
    cpu_en = 1'b0; cpu_wen = 4'h0;
  endtask

  task automatic cpu_read(input int idx, input int off);
    logic [31:0] e;
    e = ref_mem[off][idx];
    cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = mk_addr(idx, off);
    #1;
    check("rd_cpu_ready", cpu_ready, 1'b1);
    tick;
    check("rd_dout_valid", cpu_dout_valid, 1'b1);
    check("rd_dout", cpu_dout, e);
    cpu_en = 1'b0;
    tick;
    check("rd_valid_pulse", cpu_dout_valid, 1'b0);
    check("rd_dout_hold", cpu_dout, e);
  endtask

  task automatic do_evict(input int idx);
    logic [255:0] e;
    e = exp_line(idx);
    evict_req = 1'b1; evict_index = 7'(idx);
    cpu_en = 1'b1; cpu_wen = 4'hF; cpu_din = $urandom;
    cpu_addr = mk_addr(int'($urandom_range(0, SETS - 1)), int'($urandom_range(0, WORDS - 1)));
    #1;
    check("ev_cpu_ready", cpu_ready, 1'b0);
    tick;
    check("ev_valid", evict_valid, 1'b1);
    check("ev_line", evict_line, e);
    evict_req = 1'b0; cpu_en = 1'b0;
    tick;
    check("ev_valid_pulse", evict_valid, 1'b0);
    check("ev_line_hold", evict_line, e);
  endtask

  initial begin
    int op, idx, off;
    idle_inputs();
    rst = 1'b1;
    tick; tick;
    check("rst_cpu_dout", cpu_dout, 32'h0);
    check("rst_dout_valid", cpu_dout_valid, 1'b0);
    check("rst_evict_line", evict_line, 256'h0);
    check("rst_evict_valid", evict_valid, 1'b0);
    check("rst_refill_done", refill_done, 1'b0);
    check("rst_cpu_ready", cpu_ready, 1'b1);
    rst = 1'b0;

    // Fill every set so the model knows all RAM contents.
    for (int s = 0; s < SETS; s++) begin
      for (int i = 0; i < WORDS; i++) beats[i] = $urandom;
      do_refill(s, int'($urandom_range(0, WORDS - 1)), 0, 1'b0, 1'b0, WORDS, 0, 0);
    end

    for (int i = 0; i < WORDS; i++) beats[i] = 32'hA0 + 32'(i);
    do_refill(5, 3, 0, 1'b0, 1'b0, WORDS, 0, 0);
    do_evict(5);
    check("a0_line_const", evict_line,
          {32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0, 32'hA7, 32'hA6, 32'hA5});

    for (int i = 0; i < WORDS; i++) beats[i] = 32'hB0 + 32'(i);
    do_refill(9, 6, 2, 1'b0, 1'b0, WORDS, 0, 0);
    do_evict(9);

    cpu_write(2, 1, 4'hF, 32'h11223344);
    cpu_write(2, 1, 4'b0101, 32'hAABBCCDD);
    cpu_read(2, 1);
    check("byte_merge_const", cpu_dout, 32'h11BB33DD);

    for (int i = 0; i < WORDS; i++) beats[i] = $urandom;
    do_refill(20, 0, 1, 1'b1, 1'b1, WORDS, 33, 4);
    cpu_read(33, 4);
    do_evict(20);

    for (int i = 0; i < WORDS; i++) beats[i] = $urandom;
    do_refill(40, 5, 0, 1'b0, 1'b0, 4, 0, 0);
    rst = 1'b1;
    tick;
    check("midrst_refill_done", refill_done, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_cpu_ready", cpu_ready, 1'b1);
    for (int i = 0; i < WORDS; i++) beats[i] = $urandom;
    do_refill(41, 2, 0, 1'b0, 1'b0, WORDS, 0, 0);
    do_evict(40);
    do_evict(41);

    for (int n = 0; n < 300; n++) begin
      op  = int'($urandom_range(0, 3));
      idx = int'($urandom_range(0, SETS - 1));
      off = int'($urandom_range(0, WORDS - 1));
      case (op)
        0: cpu_write(idx, off, 4'($urandom_range(1, 15)), $urandom);
        1: cpu_read(idx, off);
        2: do_evict(idx);
        default: begin
          for (int i = 0; i < WORDS; i++) beats[i] = $urandom;
          do_refill(idx, off, 2, 1'b1, 1'b0, WORDS, 0, 0);
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
